// File: rtl/rv_alu.sv
// RV32I integer ALU: combinational result and compare flags, plus a
// registered copy of both that clears asynchronously on resetn.
module rv_alu (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        sub,
    input  logic [2:0]  func3,
    output logic [31:0] result,
    output logic [2:0]  compare,
    output logic [31:0] result_q,
    output logic [2:0]  compare_q
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CMP_W   = 3;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    logic [XLEN-1:0]    add_sub;
    logic [XLEN-1:0]    sll_res;
    logic [XLEN-1:0]    srl_res;
    logic [XLEN-1:0]    sra_res;
    logic [SHAMT_W-1:0] shamt;
    logic               eq;
    logic               lt_s;
    logic               lt_u;

    // Datapath primitives shared by result and compare
    always_comb begin
        shamt   = rs2[SHAMT_W-1:0];
        add_sub = sub ? (rs1 - rs2) : (rs1 + rs2);
        sll_res = rs1 << shamt;
        srl_res = rs1 >> shamt;
        sra_res = XLEN'($signed(rs1) >>> shamt);
        eq      = (rs1 == rs2);
        lt_s    = ($signed(rs1) < $signed(rs2));
        lt_u    = (rs1 < rs2);
    end

    // Operation select; sub only matters for ADD/SUB and SRL/SRA
    always_comb begin
        result = '0;
        case (func3)
            F3_ADD:  result = add_sub;
            F3_SLL:  result = sll_res;
            F3_SLT:  result = XLEN'(lt_s);
            F3_SLTU: result = XLEN'(lt_u);
            F3_XOR:  result = rs1 ^ rs2;
            F3_SR:   result = sub ? sra_res : srl_res;
            F3_OR:   result = rs1 | rs2;
            F3_AND:  result = rs1 & rs2;
            default: result = '0;
        endcase
    end

    // Compare flags are independent of func3
    always_comb begin
        compare = CMP_W'({lt_u, lt_s, eq});
    end

    // Registered copy, one-cycle latency, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q  <= '0;
            compare_q <= '0;
        end else begin
            result_q  <= result;
            compare_q <= compare;
        end
    end

endmodule

// File: tb/tb_rv_alu.sv
// Scoreboard bench for rv_alu: combinational outputs checked after settling,
// registered outputs checked from a queue one edge later.
module tb_rv_alu;

    logic        clk;
    logic        resetn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        sub;
    logic [2:0]  func3;
    logic [31:0] result;
    logic [2:0]  compare;
    logic [31:0] result_q;
    logic [2:0]  compare_q;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  cmp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rv_alu dut (
        .clk       (clk),
        .resetn    (resetn),
        .rs1       (rs1),
        .rs2       (rs2),
        .sub       (sub),
        .func3     (func3),
        .result    (result),
        .compare   (compare),
        .result_q  (result_q),
        .compare_q (compare_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model, written bit-serially to stay independent of the RTL
    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic s, input logic [2:0] f);
        logic [31:0] r;
        int          sh;
        sh = int'(b[4:0]);
        r  = a;
        case (f)
            3'd0: r = s ? (a + (~b) + 32'd1) : (a + b);
            3'd1: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
            3'd2: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: for (int i = 0; i < sh; i++) r = {s & a[31], r[31:1]};
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] model_cmp(input logic [31:0] a, input logic [31:0] b);
        logic ltu, lts;
        ltu = (a < b);
        lts = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
        return {ltu, lts, a == b};
    endfunction

    // Drive one vector, check combinational outputs, queue the registered expectation
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [2:0] f, input logic [31:0] exp_res, input string tag);
        exp_t e;
        @(negedge clk);
        rs1 = a; rs2 = b; sub = s; func3 = f;
        #1;
        check({tag, "_model"}, model_res(a, b, s, f), exp_res);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_cmp"}, 32'(compare), 32'(model_cmp(a, b)));
        e.res = exp_res;
        e.cmp = model_cmp(a, b);
        exp_q.push_back(e);
    endtask

    // Registered-output monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("reg_result", result_q, e.res);
            check("reg_compare", 32'(compare_q), 32'(e.cmp));
        end
    end

    initial begin
        logic [31:0] a, b;
        resetn = 1'b0;
        rs1 = '0; rs2 = '0; sub = 1'b0; func3 = 3'd0;
        #1;
        check("rst_result_q", result_q, 32'h0);
        check("rst_compare_q", 32'(compare_q), 32'h0);
        @(posedge clk); #1;
        check("rst_hold_result_q", result_q, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // ADD/SUB wrap
        apply(32'hFFFF_FFFF, 32'h1, 1'b0, 3'd0, 32'h0000_0000, "add_wrap");
        apply(32'hFFFF_FFFF, 32'h1, 1'b1, 3'd0, 32'hFFFF_FFFE, "sub");
        // Shifts, upper shamt bits ignored
        apply(32'h8000_0001, 32'h21, 1'b0, 3'd1, 32'h0000_0002, "sll");
        apply(32'h8000_0001, 32'h21, 1'b0, 3'd5, 32'h4000_0000, "srl");
        apply(32'h8000_0001, 32'h21, 1'b1, 3'd5, 32'hC000_0000, "sra");
        apply(32'h8000_0001, 32'h0,  1'b1, 3'd5, 32'h8000_0001, "sra0");
        apply(32'h8000_0001, 32'h20, 1'b0, 3'd1, 32'h8000_0001, "sll0");
        apply(32'h8000_0000, 32'h1F, 1'b1, 3'd5, 32'hFFFF_FFFF, "sra31");
        // Compares
        apply(32'h8000_0000, 32'h1, 1'b0, 3'd2, 32'h1, "slt");
        apply(32'h8000_0000, 32'h1, 1'b0, 3'd3, 32'h0, "sltu");
        check("cmp_010", 32'(compare), 32'b010);
        apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'd2, 32'h1, "slt_bnd");
        check("cmp_bnd", 32'(compare), 32'b010);
        apply(32'h1234, 32'h1234, 1'b1, 3'd3, 32'h0, "eq");
        check("cmp_eq", 32'(compare), 32'b001);
        // Logic, sub ignored
        for (int s = 0; s < 2; s++) begin
            apply(32'hF0F0_F0F0, 32'hFF00_FF00, 1'(s), 3'd4, 32'h0FF0_0FF0, "xor");
            apply(32'hF0F0_F0F0, 32'hFF00_FF00, 1'(s), 3'd6, 32'hFFF0_FFF0, "or");
            apply(32'hF0F0_F0F0, 32'hFF00_FF00, 1'(s), 3'd7, 32'hF000_F000, "and");
        end

        // Registered path and asynchronous mid-cycle reset
        apply(32'd2, 32'd3, 1'b0, 3'd0, 32'd5, "add23");
        @(posedge clk); #2;
        check("rq_after_edge", result_q, 32'd5);
        resetn = 1'b0;
        #1;
        check("async_rst_result_q", result_q, 32'h0);
        check("async_rst_compare_q", 32'(compare_q), 32'h0);
        check("rst_keeps_result", result, 32'd5);
        @(negedge clk);
        resetn = 1'b1;

        // Random sweep
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < 10; k++) begin
                    a = $urandom;
                    b = ($urandom_range(0, 7) == 0) ? a : 32'($urandom);
                    apply(a, b, 1'(s), 3'(f), model_res(a, b, 1'(s), 3'(f)), "rand");
                end
            end
        end

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_alu.md
RV_ALU -- requirements
Module: rv_alu

Interface
REQ-001 SHALL have ports: clk input 1 system clock (rising edge); resetn input 1 reset, asynchronous, active-low.
REQ-002 SHALL have rs1 input 32: operand A.
REQ-003 SHALL have rs2 input 32: operand B.
REQ-004 SHALL have sub input 1: op modifier; SUB when func3=0, SRA when func3=5, ignored otherwise.
REQ-005 SHALL have func3 input 3: operation select, RV32I encoding.
REQ-006 SHALL have result output 32: combinational operation result.
REQ-007 SHALL have compare output 3: combinational flags; bit0 EQ, bit1 LT (signed), bit2 LTU (unsigned).
REQ-008 SHALL have result_q output 32: registered copy of result.
REQ-009 SHALL have compare_q output 3: registered copy of compare.
REQ-010 SHALL have no parameters; data width fixed at 32.

Function
REQ-011 result SHALL be purely combinational from rs1, rs2, sub, func3; zero-cycle latency, no dependence on clk/resetn.
REQ-012 func3=0: result SHALL be rs1+rs2 when sub=0 and rs1-rs2 when sub=1, modulo 2^32; carry/overflow discarded.
REQ-013 func3=1 (SLL): result SHALL be rs1 << rs2[4:0], zero fill; rs2[31:5] ignored.
REQ-014 func3=2 (SLT): result SHALL be 32'd1 if signed(rs1) < signed(rs2), else 32'd0.
REQ-015 func3=3 (SLTU): result SHALL be 32'd1 if unsigned rs1 < unsigned rs2, else 32'd0.
REQ-016 func3=4: result SHALL be rs1 XOR rs2.
REQ-017 func3=5: result SHALL be rs1 >> rs2[4:0], zero fill (sub=0) or sign fill from rs1[31] (sub=1); rs2[31:5] ignored.
REQ-018 func3=6: result SHALL be rs1 OR rs2; func3=7: result SHALL be rs1 AND rs2.
REQ-019 sub SHALL have no effect for func3 in {1,2,3,4,6,7}.
REQ-020 compare SHALL be valid for every func3: EQ = (rs1==rs2), LT = signed(rs1)<signed(rs2), LTU = unsigned(rs1)<unsigned(rs2).
REQ-021 Shift amount 0 SHALL return rs1 unchanged for SLL/SRL/SRA.
REQ-022 Boundaries: 0x80000000 vs 0x7FFFFFFF SHALL give LT=1, LTU=0; equal operands SHALL give EQ=1, LT=0, LTU=0.
REQ-023 result_q/compare_q SHALL load result/compare on every rising clk edge while resetn=1; one-cycle latency, no enable.
REQ-024 No X SHALL propagate to outputs for any defined (non-X) input combination.

Reset
REQ-025 resetn=0 SHALL immediately (asynchronously) force result_q=32'h0 and compare_q=3'b000.
REQ-026 Registers SHALL hold reset values while resetn=0 and resume loading on the first rising clk edge after release.
REQ-027 Reset SHALL NOT affect combinational result/compare; reset mid-operation only clears registered outputs.

Verification
REQ-028 ADD/SUB: rs1=0xFFFFFFFF, rs2=1, func3=0, sub=0 -> result=0x00000000; sub=1 -> result=0xFFFFFFFE.
REQ-029 Shifts: rs1=0x80000001, rs2=0x00000021 (amt 1), func3=1 -> 0x00000002; func3=5 sub=0 -> 0x40000000; sub=1 -> 0xC0000000.
REQ-030 Compares: rs1=0x80000000, rs2=0x00000001 -> func3=2 result=1, func3=3 result=0, compare=3'b010; rs1=rs2=0x1234 -> compare=3'b001.
REQ-031 Logic: rs1=0xF0F0F0F0, rs2=0xFF00FF00 -> XOR 0x0FF00FF0, OR 0xFFF0FFF0, AND 0xF000F000; sub=1 gives identical values.
REQ-032 Registered path/reset: apply ADD 2+3, one clk edge -> result_q=5; assert resetn=0 between edges -> result_q=0 immediately while result stays 5.
REQ-033 Random sweep: all 8 func3 x sub in {0,1}, >=10 random operand pairs each, result/compare checked against REQ-012..REQ-020.
